// File: rtl/bti_arb_pkg.sv
// Shared types for the two-requester BTI arbiter: arbiter id, lock state,
// default outstanding depth and the BTI command/transaction-id widths.
package bti_arb_pkg;

  localparam int OSTD_DEFAULT = 2;
  localparam int BTI_CW       = 2;
  localparam int BTI_TW       = 4;

  typedef enum logic [BTI_CW-1:0] {
    BTI_CMD_RD = 2'd0,
    BTI_CMD_WR = 2'd1
  } bti_cmd_e;

  typedef logic [0:0] arb_id_t;

  localparam arb_id_t ARB_M0 = 1'b0;
  localparam arb_id_t ARB_M1 = 1'b1;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic arb_id_t arb_other(input arb_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/bti_arb_ostd_fifo.sv
// Order FIFO remembering which requester owns each outstanding SRAM access.
// A push while full is dropped even if a pop lands in the same cycle.
module bti_arb_ostd_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_din,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [DW-1:0]              o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop) r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/bti_arb2.sv
// Two-to-one round-robin BTI arbiter in front of a single-port SRAM with
// in-order response routing; request and response paths are combinational.
module bti_arb2
  import bti_arb_pkg::*;
#(
  parameter int BTI_AW = 32,
  parameter int BTI_DW = 32,
  parameter int OSTD   = OSTD_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  // requester 0
  input  logic                       i_m0_req_vld,
  output logic                       o_m0_req_rdy,
  input  logic [BTI_CW-1:0]          i_m0_req_cmd,
  input  logic [BTI_AW-1:0]          i_m0_req_addr,
  input  logic [BTI_DW-1:0]          i_m0_req_data,
  input  logic [BTI_DW/8-1:0]        i_m0_req_strobe,
  input  logic [BTI_TW-1:0]          i_m0_req_tid,
  output logic                       o_m0_rsp_vld,
  input  logic                       i_m0_rsp_rdy,
  output logic [BTI_DW-1:0]          o_m0_rsp_data,
  output logic                       o_m0_rsp_ok,
  output logic [BTI_TW-1:0]          o_m0_rsp_tid,
  // requester 1
  input  logic                       i_m1_req_vld,
  output logic                       o_m1_req_rdy,
  input  logic [BTI_CW-1:0]          i_m1_req_cmd,
  input  logic [BTI_AW-1:0]          i_m1_req_addr,
  input  logic [BTI_DW-1:0]          i_m1_req_data,
  input  logic [BTI_DW/8-1:0]        i_m1_req_strobe,
  input  logic [BTI_TW-1:0]          i_m1_req_tid,
  output logic                       o_m1_rsp_vld,
  input  logic                       i_m1_rsp_rdy,
  output logic [BTI_DW-1:0]          o_m1_rsp_data,
  output logic                       o_m1_rsp_ok,
  output logic [BTI_TW-1:0]          o_m1_rsp_tid,
  // shared SRAM side
  output logic                       o_s_req_vld,
  input  logic                       i_s_req_rdy,
  output logic [BTI_CW-1:0]          o_s_req_cmd,
  output logic [BTI_AW-1:0]          o_s_req_addr,
  output logic [BTI_DW-1:0]          o_s_req_data,
  output logic [BTI_DW/8-1:0]        o_s_req_strobe,
  output logic [BTI_TW-1:0]          o_s_req_tid,
  input  logic                       i_s_rsp_vld,
  output logic                       o_s_rsp_rdy,
  input  logic [BTI_DW-1:0]          i_s_rsp_data,
  input  logic                       i_s_rsp_ok,
  input  logic [BTI_TW-1:0]          i_s_rsp_tid,
  // debug view of arbiter state
  output logic                       o_dbg_ptr,
  output logic                       o_dbg_lock,
  output logic [$clog2(OSTD+1)-1:0]  o_dbg_cnt
);

  // Handshake rule on every channel: a transfer happens in a cycle where
  // vld and rdy are both high; vld/pkt must stay stable until that cycle.

  arb_id_t    r_ptr;
  arb_id_t    r_lock_id;
  arb_state_e r_state;

  arb_id_t               w_gnt;
  logic                  w_gnt_vld;
  logic [BTI_CW-1:0]     w_gnt_cmd;
  logic [BTI_AW-1:0]     w_gnt_addr;
  logic [BTI_DW-1:0]     w_gnt_data;
  logic [BTI_DW/8-1:0]   w_gnt_strobe;
  logic [BTI_TW-1:0]     w_gnt_tid;
  logic                  w_req_rdy;
  logic                  w_req_hs;
  logic                  w_full;
  logic                  w_empty;
  arb_id_t               w_head;
  logic                  w_rsp_pop;

  // A lock overrides the pointer; otherwise a lone requester always wins.
  always_comb begin
    w_gnt = r_ptr;
    if (r_state == ARB_LOCKED) w_gnt = r_lock_id;
    else if (i_m0_req_vld && !i_m1_req_vld) w_gnt = ARB_M0;
    else if (i_m1_req_vld && !i_m0_req_vld) w_gnt = ARB_M1;
  end

  always_comb begin
    w_gnt_vld    = i_m0_req_vld;
    w_gnt_cmd    = i_m0_req_cmd;
    w_gnt_addr   = i_m0_req_addr;
    w_gnt_data   = i_m0_req_data;
    w_gnt_strobe = i_m0_req_strobe;
    w_gnt_tid    = i_m0_req_tid;
    if (w_gnt == ARB_M1) begin
      w_gnt_vld    = i_m1_req_vld;
      w_gnt_cmd    = i_m1_req_cmd;
      w_gnt_addr   = i_m1_req_addr;
      w_gnt_data   = i_m1_req_data;
      w_gnt_strobe = i_m1_req_strobe;
      w_gnt_tid    = i_m1_req_tid;
    end
  end

  // rst gates the handshakes so nothing is offered or accepted in reset.
  assign w_req_rdy      = !rst && i_s_req_rdy && !w_full;
  assign o_s_req_vld    = !rst && w_gnt_vld && !w_full;
  assign o_s_req_cmd    = w_gnt_cmd;
  assign o_s_req_addr   = w_gnt_addr;
  assign o_s_req_data   = w_gnt_data;
  assign o_s_req_strobe = w_gnt_strobe;
  assign o_s_req_tid    = w_gnt_tid;
  assign o_m0_req_rdy   = w_req_rdy && (w_gnt == ARB_M0);
  assign o_m1_req_rdy   = w_req_rdy && (w_gnt == ARB_M1);
  assign w_req_hs       = o_s_req_vld && i_s_req_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= ARB_M0;
      r_lock_id <= ARB_M0;
      r_state   <= ARB_FREE;
    end else begin
      if (w_req_hs) begin
        r_ptr   <= arb_other(w_gnt);
        r_state <= ARB_FREE;
      end else if (w_gnt_vld && !i_s_req_rdy) begin
        r_state   <= ARB_LOCKED;
        r_lock_id <= w_gnt;
      end else if (!w_gnt_vld) begin
        r_state <= ARB_FREE;
      end
    end
  end

  assign o_dbg_ptr  = r_ptr;
  assign o_dbg_lock = (r_state == ARB_LOCKED);

  bti_arb_ostd_fifo #(
    .DEPTH (OSTD),
    .DW    (1)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_req_hs),
    .i_din   (w_gnt),
    .i_pop   (w_rsp_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (o_dbg_cnt)
  );

  // With nothing outstanding a response is swallowed rather than stalled.
  assign o_s_rsp_rdy = w_empty ? 1'b1 : ((w_head == ARB_M1) ? i_m1_rsp_rdy : i_m0_rsp_rdy);
  assign w_rsp_pop   = i_s_rsp_vld && o_s_rsp_rdy && !w_empty;

  assign o_m0_rsp_vld  = !rst && i_s_rsp_vld && !w_empty && (w_head == ARB_M0);
  assign o_m1_rsp_vld  = !rst && i_s_rsp_vld && !w_empty && (w_head == ARB_M1);
  assign o_m0_rsp_data = i_s_rsp_data;
  assign o_m0_rsp_ok   = i_s_rsp_ok;
  assign o_m0_rsp_tid  = i_s_rsp_tid;
  assign o_m1_rsp_data = i_s_rsp_data;
  assign o_m1_rsp_ok   = i_s_rsp_ok;
  assign o_m1_rsp_tid  = i_s_rsp_tid;

  a_no_stray_rsp : assert property (@(posedge clk) disable iff (rst)
    !(i_s_rsp_vld && w_empty))
    else $warning("bti_arb2: s_rsp with no outstanding request was dropped");

endmodule

// File: tb/tb_bti_arb2.sv
// Bench for bti_arb2: a behavioural SRAM answers shared requests, and each
// requester's expected responses are queued when its request is driven.
module tb_bti_arb2;
  import bti_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int TW   = BTI_TW;
  localparam int CW   = BTI_CW;
  localparam int EW   = 1 + TW + DW;
  localparam int CNTW = $clog2(OSTD_DEFAULT + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    req_vld = '0;
  logic [CW-1:0] req_cmd  [2];
  logic [AW-1:0] req_addr [2];
  logic [DW-1:0] req_data [2];
  logic [SW-1:0] req_strb [2];
  logic [TW-1:0] req_tid  [2];
  logic [1:0]    rsp_rdy = '0;
  logic          s_req_rdy = 1'b0;
  logic          s_rsp_vld = 1'b0;
  logic [DW-1:0] s_rsp_data = '0;
  logic          s_rsp_ok = 1'b0;
  logic [TW-1:0] s_rsp_tid = '0;

  logic          m0_req_rdy, m1_req_rdy, m0_rsp_vld, m1_rsp_vld;
  logic [DW-1:0] m0_rsp_data, m1_rsp_data;
  logic          m0_rsp_ok, m1_rsp_ok;
  logic [TW-1:0] m0_rsp_tid, m1_rsp_tid;
  logic          s_req_vld, s_rsp_rdy;
  logic [CW-1:0] s_req_cmd;
  logic [AW-1:0] s_req_addr;
  logic [DW-1:0] s_req_data;
  logic [SW-1:0] s_req_strb;
  logic [TW-1:0] s_req_tid;
  logic          dbg_ptr, dbg_lock;
  logic [CNTW-1:0] dbg_cnt;

  bti_arb2 #(.BTI_AW(AW), .BTI_DW(DW), .OSTD(OSTD_DEFAULT)) dut (
    .clk(clk), .rst(rst),
    .i_m0_req_vld(req_vld[0]), .o_m0_req_rdy(m0_req_rdy), .i_m0_req_cmd(req_cmd[0]),
    .i_m0_req_addr(req_addr[0]), .i_m0_req_data(req_data[0]), .i_m0_req_strobe(req_strb[0]),
    .i_m0_req_tid(req_tid[0]), .o_m0_rsp_vld(m0_rsp_vld), .i_m0_rsp_rdy(rsp_rdy[0]),
    .o_m0_rsp_data(m0_rsp_data), .o_m0_rsp_ok(m0_rsp_ok), .o_m0_rsp_tid(m0_rsp_tid),
    .i_m1_req_vld(req_vld[1]), .o_m1_req_rdy(m1_req_rdy), .i_m1_req_cmd(req_cmd[1]),
    .i_m1_req_addr(req_addr[1]), .i_m1_req_data(req_data[1]), .i_m1_req_strobe(req_strb[1]),
    .i_m1_req_tid(req_tid[1]), .o_m1_rsp_vld(m1_rsp_vld), .i_m1_rsp_rdy(rsp_rdy[1]),
    .o_m1_rsp_data(m1_rsp_data), .o_m1_rsp_ok(m1_rsp_ok), .o_m1_rsp_tid(m1_rsp_tid),
    .o_s_req_vld(s_req_vld), .i_s_req_rdy(s_req_rdy), .o_s_req_cmd(s_req_cmd),
    .o_s_req_addr(s_req_addr), .o_s_req_data(s_req_data), .o_s_req_strobe(s_req_strb),
    .o_s_req_tid(s_req_tid), .i_s_rsp_vld(s_rsp_vld), .o_s_rsp_rdy(s_rsp_rdy),
    .i_s_rsp_data(s_rsp_data), .i_s_rsp_ok(s_rsp_ok), .i_s_rsp_tid(s_rsp_tid),
    .o_dbg_ptr(dbg_ptr), .o_dbg_lock(dbg_lock), .o_dbg_cnt(dbg_cnt)
  );

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] pend_q[$];
  logic [1:0]    exp_gnt_q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] sram    [logic [AW-1:0]];
  logic [2:0]    seq [2];
  logic [1:0]    last_acc = '0;
  logic          slave_rsp_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : init_word(a);
  endfunction

  // driver: present a request and queue the response its owner must receive
  task automatic drive_req(input int id, input logic [CW-1:0] cmd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [SW-1:0] strb);
    logic [TW-1:0] tid;
    logic [DW-1:0] rd;
    tid = {id[0], seq[id]};
    seq[id] = seq[id] + 3'd1;
    req_vld[id] = 1'b1;
    req_cmd[id] = cmd;
    req_addr[id] = addr;
    req_data[id] = data;
    req_strb[id] = strb;
    req_tid[id] = tid;
    if (cmd == BTI_CMD_WR) begin
      ref_mem[addr] = merge(ref_word(addr), data, strb);
      rd = '0;
    end else begin
      rd = ref_word(addr);
    end
    if (id == 0) exp_q0.push_back({1'b1, tid, rd});
    else exp_q1.push_back({1'b1, tid, rd});
  endtask

  task automatic rsp_check(input int id, input logic [EW-1:0] got);
    logic [EW-1:0] e;
    if (id == 0) begin
      if (exp_q0.size() == 0) chk("rsp_m0_outstanding", exp_q0.size(), 1);
      else begin e = exp_q0.pop_front(); chk("rsp_m0", got, e); end
    end else begin
      if (exp_q1.size() == 0) chk("rsp_m1_outstanding", exp_q1.size(), 1);
      else begin e = exp_q1.pop_front(); chk("rsp_m1", got, e); end
    end
  endtask

  // drive the SRAM response for this cycle and let the DUT settle
  task automatic settle();
    if (slave_rsp_en && pend_q.size() > 0) begin
      s_rsp_vld = 1'b1;
      {s_rsp_ok, s_rsp_tid, s_rsp_data} = pend_q[0];
    end else begin
      s_rsp_vld = 1'b0;
      s_rsp_ok = 1'b0;
      s_rsp_tid = '0;
      s_rsp_data = '0;
    end
    #2;
  endtask

  // observe handshakes of this cycle, update models, advance one clock
  task automatic commit();
    logic [DW-1:0] d;
    last_acc = {req_vld[1] && m1_req_rdy, req_vld[0] && m0_req_rdy};
    if (s_req_vld && s_req_rdy) begin
      if (s_req_cmd == BTI_CMD_WR) begin
        sram[s_req_addr] = merge(sram_word(s_req_addr), s_req_data, s_req_strb);
        d = '0;
      end else begin
        d = sram_word(s_req_addr);
      end
      pend_q.push_back({1'b1, s_req_tid, d});
      if (exp_gnt_q.size() > 0) chk("grant_order", last_acc, exp_gnt_q.pop_front());
    end
    if (m0_rsp_vld && rsp_rdy[0]) rsp_check(0, {m0_rsp_ok, m0_rsp_tid, m0_rsp_data});
    if (m1_rsp_vld && rsp_rdy[1]) rsp_check(1, {m1_rsp_ok, m1_rsp_tid, m1_rsp_data});
    if (s_rsp_vld && s_rsp_rdy && pend_q.size() > 0) void'(pend_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    commit();
  endtask

  task automatic wait_acc(input int id);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      step();
      got = last_acc[id];
    end
    chk($sformatf("accept_m%0d", id), got, 1);
    req_vld[id] = 1'b0;
  endtask

  task automatic drain();
    slave_rsp_en = 1'b1;
    rsp_rdy = 2'b11;
    for (int c = 0; c < 40 && (exp_q0.size() + exp_q1.size()) > 0; c++) step();
    chk("drain_m0", exp_q0.size(), 0);
    chk("drain_m1", exp_q1.size(), 0);
  endtask

  initial begin
    int sent [2];
    for (int i = 0; i < 2; i++) begin
      req_cmd[i] = '0; req_addr[i] = '0; req_data[i] = '0;
      req_strb[i] = '0; req_tid[i] = '0; seq[i] = '0;
    end

    // reset: requests offered but nothing may pass
    repeat (2) @(posedge clk);
    #1;
    req_vld = 2'b11;
    s_req_rdy = 1'b1;
    #2;
    chk("rst_s_req_vld", s_req_vld, 0);
    chk("rst_m0_req_rdy", m0_req_rdy, 0);
    chk("rst_m1_req_rdy", m1_req_rdy, 0);
    chk("rst_ptr", dbg_ptr, 0);
    chk("rst_lock", dbg_lock, 0);
    chk("rst_cnt", dbg_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_vld = 2'b00;

    // round-robin alternation with both requesters always valid
    rsp_rdy = 2'b11;
    slave_rsp_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_gnt_q.push_back(2'b01);
      exp_gnt_q.push_back(2'b10);
    end
    drive_req(0, BTI_CMD_RD, 32'h100, '0, '0);
    drive_req(1, BTI_CMD_RD, 32'h200, '0, '0);
    sent[0] = 1;
    sent[1] = 1;
    for (int c = 0; c < 40 && req_vld != 2'b00; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (last_acc[i]) begin
          if (sent[i] < 4) begin
            drive_req(i, BTI_CMD_RD, 32'h100 * (i + 1) + 32'(4 * sent[i]), '0, '0);
            sent[i]++;
          end else begin
            req_vld[i] = 1'b0;
          end
        end
      end
    end
    chk("alt_grants_left", exp_gnt_q.size(), 0);
    drain();

    // lock: m0 held three stalled cycles although pointer favours m1
    exp_gnt_q.push_back(2'b01);
    drive_req(0, BTI_CMD_RD, 32'h180, '0, '0);
    wait_acc(0);
    chk("ptr_after_m0", dbg_ptr, 1);
    s_req_rdy = 1'b0;
    drive_req(0, BTI_CMD_RD, 32'h184, '0, '0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drive_req(1, BTI_CMD_RD, 32'h284, '0, '0);
      settle();
      chk($sformatf("lock_vld_c%0d", c), s_req_vld, 1);
      chk($sformatf("lock_tid_c%0d", c), s_req_tid, req_tid[0]);
      commit();
      chk($sformatf("lock_flag_c%0d", c), dbg_lock, 1);
    end
    s_req_rdy = 1'b1;
    exp_gnt_q.push_back(2'b01);
    exp_gnt_q.push_back(2'b10);
    settle();
    chk("lock_release_tid", s_req_tid, req_tid[0]);
    commit();
    req_vld[0] = 1'b0;
    settle();
    chk("after_lock_tid", s_req_tid, req_tid[1]);
    commit();
    chk("after_lock_acc", last_acc, 2'b10);
    req_vld[1] = 1'b0;
    chk("lock_grants_left", exp_gnt_q.size(), 0);
    drain();

    // outstanding limit, and no push in the cycle that pops a full FIFO
    slave_rsp_en = 1'b0;
    drive_req(0, BTI_CMD_RD, 32'h300, '0, '0);
    wait_acc(0);
    drive_req(1, BTI_CMD_RD, 32'h304, '0, '0);
    wait_acc(1);
    drive_req(0, BTI_CMD_RD, 32'h308, '0, '0);
    settle();
    chk("full_m0_rdy", m0_req_rdy, 0);
    chk("full_s_req_vld", s_req_vld, 0);
    chk("full_cnt", dbg_cnt, 2);
    commit();
    slave_rsp_en = 1'b1;
    settle();
    chk("full_pop_m0_rdy", m0_req_rdy, 0);
    chk("full_pop_rsp_vld", m0_rsp_vld, 1);
    commit();
    chk("full_pop_no_push", last_acc[0], 0);
    slave_rsp_en = 1'b0;
    settle();
    chk("after_pop_m0_rdy", m0_req_rdy, 1);
    commit();
    chk("after_pop_acc", last_acc[0], 1);
    req_vld[0] = 1'b0;
    chk("after_pop_cnt", dbg_cnt, 2);
    drain();

    // response back-pressure from the head requester
    slave_rsp_en = 1'b0;
    drive_req(1, BTI_CMD_RD, 32'h400, '0, '0);
    wait_acc(1);
    slave_rsp_en = 1'b1;
    rsp_rdy = 2'b01;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk($sformatf("bp_s_rsp_rdy_c%0d", c), s_rsp_rdy, 0);
      chk($sformatf("bp_m1_vld_c%0d", c), m1_rsp_vld, 1);
      chk($sformatf("bp_m0_vld_c%0d", c), m0_rsp_vld, 0);
      chk($sformatf("bp_cnt_c%0d", c), dbg_cnt, 1);
      commit();
    end
    rsp_rdy = 2'b11;
    settle();
    chk("bp_release_rdy", s_rsp_rdy, 1);
    commit();
    chk("bp_delivered", exp_q1.size(), 0);
    chk("bp_cnt_empty", dbg_cnt, 0);

    // write from m1 then read back from m0: packet passes bit-exact
    drive_req(1, BTI_CMD_WR, 32'h102, 32'hDEAD_BEEF, 4'b0011);
    settle();
    chk("wr_cmd", s_req_cmd, BTI_CMD_WR);
    chk("wr_addr", s_req_addr, 32'h102);
    chk("wr_data", s_req_data, 32'hDEAD_BEEF);
    chk("wr_strb", s_req_strb, 4'b0011);
    chk("wr_tid", s_req_tid, req_tid[1]);
    commit();
    chk("wr_acc", last_acc, 2'b10);
    req_vld[1] = 1'b0;
    drive_req(0, BTI_CMD_RD, 32'h102, 32'h1234_5678, 4'b0000);
    settle();
    chk("rd_cmd", s_req_cmd, BTI_CMD_RD);
    chk("rd_addr", s_req_addr, 32'h102);
    chk("rd_data_field", s_req_data, 32'h1234_5678);
    chk("rd_strb", s_req_strb, 4'b0000);
    chk("rd_tid", s_req_tid, req_tid[0]);
    commit();
    req_vld[0] = 1'b0;
    drain();

    // reset with two outstanding, then a stray response
    slave_rsp_en = 1'b0;
    drive_req(0, BTI_CMD_RD, 32'h500, '0, '0);
    drive_req(1, BTI_CMD_RD, 32'h504, '0, '0);
    for (int c = 0; c < 10 && req_vld != 2'b00; c++) begin
      step();
      for (int i = 0; i < 2; i++) if (last_acc[i]) req_vld[i] = 1'b0;
    end
    chk("pre_rst_cnt", dbg_cnt, 2);
    rst = 1'b1;
    req_vld = 2'b01;
    s_rsp_vld = 1'b1;
    #2;
    chk("mid_rst_s_req_vld", s_req_vld, 0);
    chk("mid_rst_m0_rdy", m0_req_rdy, 0);
    chk("mid_rst_m0_rsp_vld", m0_rsp_vld, 0);
    chk("mid_rst_m1_rsp_vld", m1_rsp_vld, 0);
    chk("mid_rst_cnt", dbg_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_vld = 2'b00;
    exp_q0.delete();
    exp_q1.delete();
    pend_q.delete();
    s_rsp_tid = 4'h9;
    s_rsp_data = 32'hBAD0_BAD0;
    s_rsp_ok = 1'b1;
    #2;
    chk("stray_s_rsp_rdy", s_rsp_rdy, 1);
    chk("stray_m0_vld", m0_rsp_vld, 0);
    chk("stray_m1_vld", m1_rsp_vld, 0);
    chk("post_rst_ptr", dbg_ptr, 0);
    @(posedge clk);
    #1;
    s_rsp_vld = 1'b0;
    chk("stray_cnt", dbg_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bti_arb2.md
BTI_ARB2 -- requirements
Module: bti_arb2

Interface
REQ-001 SHALL have parameter BTI_AW, default 32, BTI address width.
REQ-002 SHALL have parameter BTI_DW, default 32, BTI data width.
REQ-003 SHALL have parameter OSTD, default 2, maximum outstanding downstream transactions (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port m0_req_slv  bti_req_if_t.slv  bundle  requester 0 request (vld, rdy, pkt.cmd/addr/data/strobe/tid).
REQ-007 SHALL have port m0_rsp_mst  bti_rsp_if_t.mst  bundle  requester 0 response (vld, rdy, pkt.data/ok/tid).
REQ-008 SHALL have port m1_req_slv  bti_req_if_t.slv  bundle  requester 1 request.
REQ-009 SHALL have port m1_rsp_mst  bti_rsp_if_t.mst  bundle  requester 1 response.
REQ-010 SHALL have port s_req_mst  bti_req_if_t.mst  bundle  shared request to the single-port BTI SRAM.
REQ-011 SHALL have port s_rsp_slv  bti_rsp_if_t.slv  bundle  shared response from the SRAM.

Function
REQ-012 Arbitration SHALL be round-robin: a 1-bit priority pointer names the preferred requester; when both vld, preferred wins; when one vld, it wins.
REQ-013 After each s_req handshake, the pointer SHALL move to the requester not granted.
REQ-014 Lock: if granted requester has vld=1 while s_req.rdy=0, grant SHALL be held next cycle regardless of pointer; lock clears on handshake.
REQ-015 s_req.vld = granted vld AND NOT fifo_full; s_req.pkt = granted pkt, unmodified (tid passed through).
REQ-016 Granted requester rdy = s_req.rdy AND NOT fifo_full; non-granted requester rdy SHALL be 0.
REQ-017 Each s_req handshake SHALL push the granted id (1 bit) into an OSTD-deep order FIFO.
REQ-018 When FIFO full, no push SHALL occur, even if a pop happens the same cycle (no full-pop-push bypass).
REQ-019 Responses SHALL be routed in order to the requester at FIFO head: that rsp.vld = s_rsp.vld, rsp.pkt = s_rsp.pkt; the other rsp.vld = 0.
REQ-020 s_rsp.rdy SHALL equal rdy of the head requester; each s_rsp handshake pops the FIFO.
REQ-021 Simultaneous push and pop when not full SHALL leave occupancy unchanged; pointers wrap modulo OSTD.
REQ-022 s_rsp.vld with FIFO empty is a protocol error: s_rsp.rdy=1, both rsp.vld=0, response dropped, simulation assertion fires.
REQ-023 Zero added latency: request path and response path SHALL be combinational through the block; only pointer, lock and FIFO are registered.

Reset
REQ-024 On rst: pointer=requester 0, lock clear, FIFO empty (occupancy 0, rd/wr pointers 0).
REQ-025 During and right after reset: s_req.vld=0, m0/m1 rsp.vld=0, m0/m1 req.rdy=0 until first cycle with rst=0.
REQ-026 Reset mid-transaction SHALL discard outstanding entries; responses arriving after reset fall under REQ-022.

Structure
REQ-027 Arbiter id type (1 bit) and OSTD default SHALL live in a shared package bti_arb_pkg; BTI cmd/pkt types stay in the existing BTI interface header.
REQ-028 Order FIFO SHALL be one sub-module bti_arb_ostd_fifo (param DEPTH, DW; push/pop/full/empty/head).

Verification
REQ-029 Both requesters vld every cycle, s_req.rdy=1, s_rsp.rdy=1 -> grants alternate m0,m1,m0,m1; each response reaches matching requester with matching tid.
REQ-030 m0 vld with s_req.rdy=0 for 3 cycles while m1 also vld, pointer=m1 after prior grant -> m0 held locked 3 cycles, m0 granted cycle 4, m1 granted next.
REQ-031 OSTD=2, two requests accepted, s_rsp.vld=0 -> third request sees rdy=0; one s_rsp handshake + new request same cycle -> request not accepted that cycle, accepted next.
REQ-032 Head=m1, m1_rsp.rdy=0 for 2 cycles -> s_rsp.rdy=0 those cycles, m0_rsp.vld=0, no pop; release -> delivered to m1.
REQ-033 rst asserted with 2 outstanding, then a stray s_rsp.vld -> outputs reset per REQ-025, stray response dropped, assertion fires.
REQ-034 Write (strobe 4'b0011, addr 0x102) from m1 then read same addr from m0 -> s_req pkt bit-identical to inputs; read data routed to m0 only.
